// File: rtl/mul_seq_radix_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the iterative radix multiplier.
//   - FSM state encodings (2-bit): IDLE, RUN, FIX, DONE
//   - num_iter()  : number of RUN iterations, LEN/STEP
//   - cnt_width() : iteration counter width, $clog2(LEN/STEP), minimum 1
// ---------------------------------------------------------------------------
package mul_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic int num_iter(input int len, input int step);
        return len / step;
    endfunction

    // A single-iteration configuration (STEP == LEN) still needs a 1-bit counter.
    function automatic int cnt_width(input int len, input int step);
        int w;
        w = $clog2(len / step);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mul_seq_radix_if.sv
// ---------------------------------------------------------------------------
// mul_seq_radix_if
// Request/response bundle of the iterative multiplier.
//   START  : operation request (master -> slave)
//   SIGNED : 1 = two's complement operands, 0 = unsigned (master -> slave)
//   A, B   : LEN-bit multiplicand / multiplier (master -> slave)
//   Y      : 2*LEN-bit product (slave -> master)
//   DONE   : result valid (slave -> master)
//   BUSY   : operation in progress (slave -> master)
// ---------------------------------------------------------------------------
interface mul_seq_radix_if #(
    parameter int LEN = 16
);

    logic                 START;
    logic                 SIGNED;
    logic [LEN-1:0]       A;
    logic [LEN-1:0]       B;
    logic [2*LEN-1:0]     Y;
    logic                 DONE;
    logic                 BUSY;

    modport master (
        output START, SIGNED, A, B,
        input  Y, DONE, BUSY
    );

    modport slave (
        input  START, SIGNED, A, B,
        output Y, DONE, BUSY
    );

endinterface

// File: rtl/mul_seq_radix_step.sv
// ---------------------------------------------------------------------------
// mul_seq_step
// One combinational radix-2^STEP iteration of a shift-right multiplier.
// The product register holds {partial_sum_hi, remaining_multiplier_bits}.
// The low STEP bits select the multiple of A added into the high half, and
// the whole register is then shifted right by STEP.
//   i_prod : current product/multiplier register (2*LEN)
//   i_a    : multiplicand (LEN)
//   o_prod : updated register after accumulate and shift (2*LEN)
// ---------------------------------------------------------------------------
module mul_seq_step #(
    parameter int LEN  = 16,
    parameter int STEP = 2
) (
    input  logic [2*LEN-1:0] i_prod,
    input  logic [LEN-1:0]   i_a,
    output logic [2*LEN-1:0] o_prod
);

    localparam int PW = LEN + STEP;

    logic [STEP-1:0]       w_slice;
    logic [PW-1:0]         w_pp;
    logic [PW-1:0]         w_sum;
    logic [2*LEN+STEP-1:0] w_wide;

    assign w_slice = i_prod[STEP-1:0];
    assign w_pp    = PW'(i_a) * PW'(w_slice);
    // High half is always < 2^LEN, so the sum fits in LEN+STEP bits.
    assign w_sum   = PW'(i_prod[2*LEN-1:LEN]) + w_pp;
    assign w_wide  = {w_sum, i_prod[LEN-1:0]};
    assign o_prod  = w_wide[2*LEN+STEP-1:STEP];

endmodule

// File: rtl/mul_seq_radix.sv
// ---------------------------------------------------------------------------
// mul_seq_radix
// Iterative multiplier retiring STEP multiplier bits per clock and returning
// the full 2*LEN-bit product, in unsigned or two's complement mode.
// Latency: START accepted at edge 0 -> DONE first high after edge N+1,
// N = LEN/STEP.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : slave side of mul_seq_radix_if (START/SIGNED/A/B in,
//           Y/DONE/BUSY out)
// ---------------------------------------------------------------------------
module mul_seq_radix
    import mul_seq_pkg::*;
#(
    parameter int LEN  = 16,
    parameter int STEP = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    mul_seq_radix_if.slave    bus
);

    localparam int              N    = num_iter(LEN, STEP);
    localparam int              CW   = cnt_width(LEN, STEP);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    generate
        if (LEN < 2) begin : g_bad_len
            $error("mul_seq_radix: LEN must be at least 2");
        end
        if (STEP < 1) begin : g_bad_step
            $error("mul_seq_radix: STEP must be at least 1");
        end else if ((LEN % STEP) != 0) begin : g_bad_div
            $error("mul_seq_radix: LEN must be a multiple of STEP");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [LEN-1:0]     r_a;
    logic [LEN-1:0]     r_b;
    logic               r_signed;
    logic [2*LEN-1:0]   r_prod;
    logic [2*LEN-1:0]   r_y;

    logic [2*LEN-1:0]   w_step_prod;
    logic [2*LEN-1:0]   w_corr_a;
    logic [2*LEN-1:0]   w_corr_b;
    logic [2*LEN-1:0]   w_fixed;
    logic               w_accept;

    mul_seq_step #(
        .LEN  (LEN),
        .STEP (STEP)
    ) u_step (
        .i_prod (r_prod),
        .i_a    (r_a),
        .o_prod (w_step_prod)
    );

    // The core always forms the unsigned product of the raw bit patterns.
    // A two's complement operand with its sign bit set is worth 2^LEN less
    // than its unsigned reading, so the signed product is recovered by
    // subtracting the other operand shifted up by LEN, once per negative
    // operand, modulo 2^(2*LEN).
    assign w_corr_a = r_a[LEN-1] ? {r_b, {LEN{1'b0}}} : '0;
    assign w_corr_b = r_b[LEN-1] ? {r_a, {LEN{1'b0}}} : '0;
    assign w_fixed  = r_signed ? (r_prod - w_corr_a - w_corr_b) : r_prod;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.START;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_prod   <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_cnt    <= '0;
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_signed <= bus.SIGNED;
                        // Multiplier bits ride in the low half and are
                        // consumed LSB first as the register shifts right.
                        r_prod   <= {{LEN{1'b0}}, bus.B};
                    end
                end
                RUN: begin
                    r_prod <= w_step_prod;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_y     <= w_fixed;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Y    = r_y;
    assign bus.DONE = (r_state == DONE);
    assign bus.BUSY = (r_state == RUN) || (r_state == FIX);

endmodule

// File: tb/tb_mul_seq_radix.sv
module tb_mul_seq_radix;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mul_seq_radix_if #(.LEN(16)) bus1 ();
    mul_seq_radix_if #(.LEN(16)) bus2 ();
    mul_seq_radix_if #(.LEN(16)) bus4 ();
    mul_seq_radix_if #(.LEN(16)) bus16 ();

    mul_seq_radix #(.LEN(16), .STEP(1))  u_s1  (.CLK(clk), .RST_N(rst_n), .bus(bus1));
    mul_seq_radix #(.LEN(16), .STEP(2))  u_s2  (.CLK(clk), .RST_N(rst_n), .bus(bus2));
    mul_seq_radix #(.LEN(16), .STEP(4))  u_s4  (.CLK(clk), .RST_N(rst_n), .bus(bus4));
    mul_seq_radix #(.LEN(16), .STEP(16)) u_s16 (.CLK(clk), .RST_N(rst_n), .bus(bus16));

    int n_cmp  = 0;
    int n_fail = 0;
    int lat [4]  = '{17, 9, 5, 2};
    int stp [4]  = '{1, 2, 4, 16};
    logic [31:0] prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic sg, input logic [15:0] a, input logic [15:0] b);
        bus1.START  = st; bus1.SIGNED  = sg; bus1.A  = a; bus1.B  = b;
        bus2.START  = st; bus2.SIGNED  = sg; bus2.A  = a; bus2.B  = b;
        bus4.START  = st; bus4.SIGNED  = sg; bus4.A  = a; bus4.B  = b;
        bus16.START = st; bus16.SIGNED = sg; bus16.A = a; bus16.B = b;
    endtask

    task automatic sample(output logic [31:0] y [4], output logic d [4], output logic bz [4]);
        y[0] = bus1.Y;  d[0] = bus1.DONE;  bz[0] = bus1.BUSY;
        y[1] = bus2.Y;  d[1] = bus2.DONE;  bz[1] = bus2.BUSY;
        y[2] = bus4.Y;  d[2] = bus4.DONE;  bz[2] = bus4.BUSY;
        y[3] = bus16.Y; d[3] = bus16.DONE; bz[3] = bus16.BUSY;
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sb;
        if (s) begin
            sa = 32'(signed'(a));
            sb = 32'(signed'(b));
            return 32'(sa * sb);
        end
        return 32'({16'h0, a}) * 32'({16'h0, b});
    endfunction

    // Launch one operation on all instances, then watch 17 edges.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] exp, input bit full, input bit pulse);
        int          first [4];
        logic [31:0] y [4];
        logic        d [4];
        logic        bz [4];
        first = '{default: 0};
        set_in(1'b1, s, a, b);
        tick();
        set_in(1'b0, 1'bx, 16'hxxxx, 16'hxxxx);
        for (int k = 1; k <= 17; k++) begin
            if (pulse && k == 4) begin
                bus1.START = 1'b1; bus1.SIGNED = 1'b0; bus1.A = 16'h0007; bus1.B = 16'h0007;
                bus2.START = 1'b1; bus2.SIGNED = 1'b0; bus2.A = 16'h0007; bus2.B = 16'h0007;
                bus4.START = 1'b1; bus4.SIGNED = 1'b0; bus4.A = 16'h0007; bus4.B = 16'h0007;
            end
            tick();
            if (pulse && k == 4) begin
                set_in(1'b0, 1'bx, 16'hxxxx, 16'hxxxx);
            end
            sample(y, d, bz);
            for (int i = 0; i < 4; i++) begin
                if (d[i] === 1'b1 && first[i] == 0) first[i] = k;
                if (full) begin
                    chk($sformatf("%s/s%0d/e%0d/done", tag, stp[i], k), 32'(d[i]), 32'(k >= lat[i]));
                    chk($sformatf("%s/s%0d/e%0d/busy", tag, stp[i], k), 32'(bz[i]), 32'(k < lat[i]));
                    if (k < lat[i])
                        chk($sformatf("%s/s%0d/e%0d/yhold", tag, stp[i], k), y[i], prev);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s/s%0d/latency", tag, stp[i]), 32'(first[i]), 32'(lat[i]));
            chk($sformatf("%s/s%0d/y", tag, stp[i]), y[i], exp);
        end
        prev = exp;
    endtask

    initial begin
        logic [31:0] y [4];
        logic        d [4];
        logic        bz [4];
        logic [15:0] sa, sb;

        set_in(1'b0, 1'b0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        sample(y, d, bz);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset/s%0d/y", stp[i]), y[i], 32'h0);
            chk($sformatf("reset/s%0d/done", stp[i]), 32'(d[i]), 32'h0);
            chk($sformatf("reset/s%0d/busy", stp[i]), 32'(bz[i]), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        prev = 32'h0;

        run_op("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1, 1'b0);
        run_op("s_ffff_0003", 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD, 1'b1, 1'b0);
        run_op("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1, 1'b0);
        run_op("u_8000_8000", 16'h8000, 16'h8000, 1'b0, 32'h40000000, 1'b1, 1'b0);
        run_op("s_8000_0001", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b1, 1'b0);
        run_op("ignored_start", 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 1'b1, 1'b1);

        // Asynchronous reset between edges 4 and 5 of an operation.
        set_in(1'b1, 1'b0, 16'h1234, 16'h5678);
        tick();
        set_in(1'b0, 1'bx, 16'hxxxx, 16'hxxxx);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        sample(y, d, bz);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_rst/s%0d/y", stp[i]), y[i], 32'h0);
            chk($sformatf("async_rst/s%0d/done", stp[i]), 32'(d[i]), 32'h0);
            chk($sformatf("async_rst/s%0d/busy", stp[i]), 32'(bz[i]), 32'h0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        sample(y, d, bz);
        chk("post_rst/s2/y", y[1], 32'h0);
        chk("post_rst/s2/busy", 32'(bz[1]), 32'h0);
        prev = 32'h0;

        run_op("after_rst", 16'h0002, 16'h0003, 1'b0, 32'h00000006, 1'b1, 1'b0);
        run_op("back2back", 16'h1234, 16'h0010, 1'b0, 32'h00012340, 1'b1, 1'b0);

        for (int i = 0; i < 100; i++) begin
            sa = 16'(i * 193);
            sb = 16'(i * 1543);
            run_op($sformatf("sweep_u%0d", i), sa, sb, 1'b0, ref_prod(sa, sb, 1'b0), 1'b0, 1'b0);
            run_op($sformatf("sweep_s%0d", i), sa, sb, 1'b1, ref_prod(sa, sb, 1'b1), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_radix.md
Name: mul_seq_radix

Overview:
Parametrised iterative multiplier and the next-generation replacement for the single-mode sequential multiplier. It retires STEP multiplier bits per cycle and returns the full 2*LEN-bit product. A per-operation SIGNED mode selects two's-complement or unsigned operands, and BUSY/DONE form the handshake. It sits in datapath slices where a combinational array multiplier is too large.

Parameters:
LEN, 16, operand width; must be at least 2.
STEP, 2, multiplier bits retired per cycle; must be at least 1, and LEN % STEP == 0 is checked at elaboration.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  request; sampled only when not BUSY.
SIGNED  in  1  1 = both operands two's complement, 0 = unsigned; sampled with START.
A  in  LEN  multiplicand; sampled on the accepting edge only, may be X otherwise.
B  in  LEN  multiplier; sampled on the accepting edge only, may be X otherwise.
Y  out  2*LEN  full product.
DONE  out  1  result valid.
BUSY  out  1  operation in progress.

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE, Y=0, DONE=0, BUSY=0, internal registers cleared. Reset mid-operation aborts the operation with no partial result visible.
- N = LEN/STEP iterations.
- States:
  - IDLE.
  - RUN: counter 0..N-1.
  - FIX: sign correction and result writeback.
  - DONE.
- Transitions:
  - IDLE/DONE, START=1: go to RUN. Latch A, B and SIGNED; clear the accumulator and counter; BUSY=1 and DONE=0 from the next cycle.
  - RUN: add a STEP-bit slice of B (LSB first) times A into the accumulator, then shift. Move to FIX after the counter reaches N-1.
  - FIX: apply signed correction if SIGNED, write Y, then go to DONE.
  - DONE: DONE=1, BUSY=0. Y and DONE hold indefinitely until the next accepted START.
- Latency: with START accepted at edge 0, DONE is first high after edge N+1. For LEN=16, STEP=2 that is 9 edges.
- START while BUSY (RUN/FIX) is ignored; the operation in flight is unaffected and the ignored request is lost.
- Y changes only on the FIX→DONE edge or at reset. It keeps the previous result while a new operation runs.
- Arithmetic rules:
  - Unsigned: Y = A*B, exact over 2*LEN bits.
  - Signed: Y = $signed(A)*$signed(B), exact, including -2^(LEN-1) * -2^(LEN-1).
  - No truncation and no overflow flag.
- Back-to-back: START in the DONE state is accepted. DONE drops after that edge, so there are zero idle cycles between operations.
- Zero operands take the full latency; there is no early termination.

Decomposition:
- Shared package mul_seq_pkg holds:
  - state encoding constants: IDLE, RUN, FIX, DONE (2-bit);
  - the function computing N and the counter width, $clog2(LEN/STEP) with a minimum of 1.
- One sub-module, mul_seq_step: combinational accumulate of a STEP-bit multiplier slice times a LEN-bit multiplicand into the running partial sum, plus shift.
  - Instantiated once in the top FSM.
  - Unit-testable separately.

Test Plan:
- LEN=16, STEP=2: unsigned 0xFFFF*0xFFFF → Y=0xFFFE0001; DONE first high exactly 9 edges after the START edge; BUSY high for edges 1..8.
- SIGNED=1: 0xFFFF*0x0003 → Y=0xFFFFFFFD. SIGNED=1: 0x8000*0x8000 → Y=0x40000000. SIGNED=0 with the same operands → Y=0x40000000 (unsigned 32768²). SIGNED=1: 0x8000*0x0001 → Y=0xFFFF8000.
- START 0x0003*0x0005, then pulse START with 0x0007*0x0007 at edge 4 → pulse ignored; Y=0x0000000F; DONE at edge 9.
- Drive RST_N low between edges 4 and 5 of an operation → Y=0, DONE=0 and BUSY=0 immediately, without a clock edge. After release, 0x0002*0x0003 → Y=0x00000006 after 9 edges.
- Back-to-back: while in DONE with Y=0x00000006, START 0x1234*0x0010 → DONE low after that edge, Y holds 0x00000006 until completion, then Y=0x00012340.
- Sweep i=0..99: A=i*193, B=i*1543 (mod 2^16), both modes → Y equals the exact 32-bit reference product; repeat for STEP=1, 4 and 16 with latencies 17, 5 and 2.
